// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in, stage controls and
// statistics out.
//   master : pipeline side, drives ID/EX/MEM status and observes controls
//   slave  : hazard controller
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             ifid_write, idex_write, exmem_write, memwb_write;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               state, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               state, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves data-memory waits (highest priority), taken branches in EX and
// load-use hazards, driving pipeline-register write/flush and PC write.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   hz         : hazard_ctrl_if.slave (hazard sources in, controls, state,
//                saturating stall/flush counters, sticky mem_timeout out)
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_t           st;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt, wait_nxt;
    logic             mem_timeout;
    logic             lu, freeze, branch, ld_stall, pc_en;

    always_comb begin
        lu = hz.ex_memread && (hz.ex_rd != '0) &&
             ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
              (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
        // Once waiting, only mem_ready matters: the MEM instruction is frozen.
        freeze   = (st == MEM_WAIT) ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);
        branch   = !freeze && hz.ex_branch_taken;
        // A taken branch discards the ID instruction, so its hit is moot.
        ld_stall = !freeze && !branch && lu;
        pc_en    = !(freeze || ld_stall);
        wait_nxt = (st == RUN) ? CNT_W'(1)
                 : ((wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1));
    end

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_write  = 1'b1;
        hz.exmem_write = 1'b1;
        hz.memwb_write = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_flush = 1'b0;
        hz.memwb_flush = 1'b0;
        if (reset) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_write = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
            hz.memwb_flush = 1'b1;
        end else if (freeze) begin
            // Hold IF..MEM, drain a bubble into WB.
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_flush = 1'b1;
        end else if (branch) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
        end else if (ld_stall) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= RUN;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (freeze) begin
                st       <= MEM_WAIT;
                wait_cnt <= wait_nxt;
                if (wait_nxt >= WAIT_LIM) mem_timeout <= 1'b1;
            end else begin
                st       <= RUN;
                wait_cnt <= '0;
            end
        end
    end

    assign hz.state       = st;
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;
    assign hz.mem_timeout = mem_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int REG_W    = 5;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    // ctl = {pc_write, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f}
    typedef enum int {K_RST, K_NONE, K_FREEZE, K_BR, K_LU} kind_t;

    typedef struct {
        logic [8:0]       ctl;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             to;
        bit               regs_ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();
    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(rst), .hz(hif)
    );

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: a cycle-level view of the pipeline's condition.
    bit m_known = 0, m_waiting = 0, m_to = 0;
    int m_wlen = 0, m_stall = 0, m_flush = 0;

    function automatic logic [8:0] ctl_of(kind_t k);
        case (k)
            K_RST:    return 9'b0_0000_1111;
            K_FREEZE: return 9'b0_0001_0001;
            K_BR:     return 9'b1_1111_1100;
            K_LU:     return 9'b0_0111_0100;
            default:  return 9'b1_1111_0000;
        endcase
    endfunction

    function automatic bit load_use_hit();
        logic [REG_W-1:0] src [2];
        bit               used[2];
        src[0] = hif.id_rs1;  used[0] = hif.id_use_rs1;
        src[1] = hif.id_rs2;  used[1] = hif.id_use_rs2;
        if (!hif.ex_memread || hif.ex_rd == 0) return 0;
        foreach (src[i]) if (used[i] && src[i] == hif.ex_rd) return 1;
        return 0;
    endfunction

    // Record the expectation for the current inputs, advance the model,
    // then move to #1 after the next edge.
    task automatic go();
        exp_t  e;
        kind_t k;
        bit    mem_busy;
        mem_busy = m_waiting ? !hif.mem_ready : (hif.mem_req && !hif.mem_ready);
        if (rst)                      k = K_RST;
        else if (mem_busy)            k = K_FREEZE;
        else if (hif.ex_branch_taken) k = K_BR;
        else if (load_use_hit())      k = K_LU;
        else                          k = K_NONE;
        e.ctl = ctl_of(k);
        e.st = m_waiting ? 2'd1 : 2'd0;
        e.sc = CNT_W'(m_stall);
        e.fc = CNT_W'(m_flush);
        e.to = m_to;
        e.regs_ok = m_known;
        q.push_back(e);
        if (k == K_RST) begin
            m_known = 1; m_waiting = 0; m_to = 0;
            m_wlen = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (k == K_FREEZE || k == K_LU) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (k == K_BR) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
            if (k == K_FREEZE) begin
                m_waiting = 1;
                m_wlen++;
                if (m_wlen >= MAX_WAIT) m_to = 1;
            end else begin
                m_waiting = 0;
                m_wlen = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.id_rs1 = '0; hif.id_rs2 = '0;
        hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
        hif.ex_memread = 0; hif.ex_rd = '0; hif.ex_branch_taken = 0;
        hif.mem_req = 0; hif.mem_ready = 0;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rd);
        hif.ex_memread = 1; hif.ex_rd = rd;
        hif.id_rs2 = 5'd5; hif.id_use_rs2 = 1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: compare what the DUT presents mid-cycle with the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            chk("ctl", 16'({hif.pc_write, hif.ifid_write, hif.idex_write, hif.exmem_write,
                            hif.memwb_write, hif.ifid_flush, hif.idex_flush, hif.exmem_flush,
                            hif.memwb_flush}), 16'(e.ctl));
            if (e.regs_ok) begin
                chk("state", 16'(hif.state), 16'(e.st));
                chk("stall_cnt", 16'(hif.stall_cnt), 16'(e.sc));
                chk("flush_cnt", 16'(hif.flush_cnt), 16'(e.fc));
                chk("mem_timeout", 16'(hif.mem_timeout), 16'(e.to));
            end
        end
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        // Reset for two cycles, then idle.
        rst = 1; go(); go();
        rst = 0; go(); go();
        // Load-use on rs2, then same with ex_rd = 0.
        set_lu(5'd5); go(); idle(); go();
        set_lu(5'd0); go(); idle(); go();
        // Branch together with load-use hit.
        set_lu(5'd5); hif.ex_branch_taken = 1; go(); idle(); go();
        // Three-cycle memory wait, released on the fourth.
        hif.mem_req = 1; hif.mem_ready = 0;
        repeat (3) go();
        hif.mem_ready = 1; go(); idle(); go();
        // Same-cycle ready: no stall.
        hif.mem_req = 1; hif.mem_ready = 1; go(); idle(); go();
        // Six wait cycles: timeout, sticky past release, cleared by reset.
        hif.mem_req = 1; hif.mem_ready = 0;
        repeat (6) go();
        hif.mem_ready = 1; go(); idle(); go(); go();
        rst = 1; go(); rst = 0; go();
        // Reset mid-wait.
        hif.mem_req = 1; hif.mem_ready = 0; go(); go();
        rst = 1; go(); rst = 0; idle(); go();
        // Saturation of the stall counter.
        set_lu(5'd5);
        repeat (20) go();
        idle(); go();
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            hif.id_rs1 = REG_W'($urandom_range(0, 3));
            hif.id_rs2 = REG_W'($urandom_range(0, 3));
            hif.id_use_rs1 = 1'($urandom);
            hif.id_use_rs2 = 1'($urandom);
            hif.ex_memread = 1'($urandom);
            hif.ex_rd = REG_W'($urandom_range(0, 3));
            hif.ex_branch_taken = ($urandom_range(0, 3) == 0);
            hif.mem_req = 1'($urandom);
            hif.mem_ready = ($urandom_range(0, 9) < 4);
            go();
        end
        rst = 0; idle();
        // Drain: monitor must consume every expectation within a few cycles.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
